moore_seq_tx: RTL and testbench
===============================

Name: moore_seq_tx

Overview:
Serial pattern transmitter: the driving end of the single-bit stream that the team's Moore sequence detectors consume. It loads a WIDTH-bit pattern on a start request and shifts it out MSB-first on x, one bit per clock. It repeats the pattern a programmable number of times, with a fixed idle gap between repetitions, and signals completion. The control is a Moore FSM with registered outputs; it serves as a stimulus source for detector blocks and as a reusable serial framer.

Parameters:
WIDTH, 8, pattern length in bits (≥2)
CNT_W, 4, width of the repeat-count input
GAP, 2, idle cycles (x=0, valid=0) between repetitions; 0 = back-to-back

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
pattern  in  WIDTH  bits to transmit, MSB first; captured on accepted start
repeat_n  in  CNT_W  number of transmissions; captured on accepted start
x  out  1  serial data bit (registered)
valid  out  1  high while x carries a pattern bit
busy  out  1  high from cycle after accepted start until DONE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE; x=0, valid=0, busy=0, done=0; shift register, bit counter and repeat counter cleared. Reset mid-operation aborts immediately; no done pulse.
- All outputs are decoded from registered state and data only (Moore); no combinational path from any input to any output.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: x=0, valid=0, busy=0. If start=1 at edge k:
  - repeat_n≠0: capture pattern into shift reg, repeat_n into rep counter, bit counter=WIDTH-1, go to SHIFT. At cycle k+1: valid=1, busy=1, x=pattern[WIDTH-1].
  - repeat_n=0: go directly to DONE.
- SHIFT: each cycle, x = current MSB of shift reg; shift left; decrement bit counter. Exactly WIDTH valid cycles per repetition. After the last bit (bit counter=0):
  - rep counter>1 and GAP>0: decrement rep, go to GAP for GAP cycles (x=0, valid=0, busy=1), reload shift reg from captured pattern, then return to SHIFT.
  - rep counter>1 and GAP=0: decrement rep, reload, stay in SHIFT; next cycle is the MSB again, with valid continuous.
  - rep counter=1: go to DONE.
- DONE: exactly one cycle, done=1, busy=0, valid=0, x=0; then IDLE unconditionally.
- start is ignored in SHIFT, GAP and DONE (no queuing). The earliest re-accept is the IDLE cycle after DONE.
- pattern/repeat_n changes after capture have no effect on the current transmission.
- Total latency from accepting edge to done pulse: N·WIDTH + (N-1)·GAP + 1 cycles, where N=repeat_n≥1. For N=0 the done pulse occurs in the cycle after the accepting edge.
- Counters: bit counter ceil(log2(WIDTH)) bits; rep counter CNT_W bits, no wrap (it only decrements from captured value ≥1). repeat_n max = 2^CNT_W-1 is supported.

Test Plan:
1. WIDTH=4, GAP=2: rst low 10 ns then high; start with pattern=4'b1101, repeat_n=1 -> over 4 cycles x=1,1,0,1 with valid=1, busy=1; next cycle done=1, busy=0; then IDLE with x=0.
2. WIDTH=4, GAP=2: pattern=4'b1110, repeat_n=2 -> x/valid sequence 1,1,1,0 (valid=1), 0,0 (valid=0, busy=1), 1,1,1,0 (valid=1), then done pulse. Total 11 cycles from accept to done.
3. GAP=0, pattern=4'b1010, repeat_n=3 -> 12 consecutive valid cycles of 1010 1010 1010, then done. valid never drops in between.
4. repeat_n=0 with start -> valid stays 0 and busy stays 0; done=1 on the cycle after the accepting edge.
5. During the SHIFT of pattern 4'b1101, assert start with pattern=4'b0000 -> ignored; the stream completes as 1101; only one done pulse.
6. Drive rst=0 mid-SHIFT (after 2 bits) -> x, valid, busy and done go to 0 immediately, asynchronously. After release, start with 4'b0110, repeat_n=1 -> a clean 0,1,1,0 followed by done.

Source files
------------

// File: rtl/moore_seq_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first on x,
// repeated repeat_n times with GAP idle cycles between repetitions, then pulses done.
module moore_seq_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP != 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bitcnt_q;
    logic [CNT_W-1:0] rep_q;
    logic [GW-1:0]    gapcnt_q;

    // x always holds the bit on the wire; shreg_q holds the bits still to come.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            rep_q    <= '0;
            gapcnt_q <= '0;
            x        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (repeat_n != '0) begin
                            pat_q    <= pattern;
                            rep_q    <= repeat_n;
                            shreg_q  <= {pattern[WIDTH-2:0], 1'b0};
                            bitcnt_q <= BIT_LAST;
                            x        <= pattern[WIDTH-1];
                            valid    <= 1'b1;
                            busy     <= 1'b1;
                            state_q  <= StShift;
                        end else begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StShift: begin
                    if (bitcnt_q != '0) begin
                        x        <= shreg_q[WIDTH-1];
                        shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
                        bitcnt_q <= bitcnt_q - BW'(1);
                    end else if (rep_q != CNT_W'(1)) begin
                        rep_q <= rep_q - CNT_W'(1);
                        if (GAP != 0) begin
                            x        <= 1'b0;
                            valid    <= 1'b0;
                            gapcnt_q <= GAP_LAST;
                            state_q  <= StGap;
                        end else begin
                            // Back-to-back: next MSB follows immediately, valid stays high.
                            x        <= pat_q[WIDTH-1];
                            shreg_q  <= {pat_q[WIDTH-2:0], 1'b0};
                            bitcnt_q <= BIT_LAST;
                        end
                    end else begin
                        x       <= 1'b0;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StGap: begin
                    if (gapcnt_q != '0) begin
                        gapcnt_q <= gapcnt_q - GW'(1);
                    end else begin
                        x        <= pat_q[WIDTH-1];
                        shreg_q  <= {pat_q[WIDTH-2:0], 1'b0};
                        bitcnt_q <= BIT_LAST;
                        valid    <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    x       <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_seq_tx.sv
// Directed bench for moore_seq_tx: a GAP=2 and a GAP=0 instance (WIDTH=4) share stimulus;
// each cycle's {x,valid,busy,done} is compared against hand-written expectations.
module tb_moore_seq_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_n;

    logic x_g, valid_g, busy_g, done_g;
    logic x_n, valid_n, busy_n, done_n;
    logic [3:0] obs_g;
    logic [3:0] obs_n;

    int vecs;
    int errs;

    assign obs_g = {x_g, valid_g, busy_g, done_g};
    assign obs_n = {x_n, valid_n, busy_n, done_n};

    moore_seq_tx #(.WIDTH(4), .CNT_W(4), .GAP(2)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .x        (x_g),
        .valid    (valid_g),
        .busy     (busy_g),
        .done     (done_g)
    );

    moore_seq_tx #(.WIDTH(4), .CNT_W(4), .GAP(0)) u_nogap (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .x        (x_n),
        .valid    (valid_n),
        .busy     (busy_n),
        .done     (done_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start request; returns just after the accepting edge.
    task automatic launch(input logic [3:0] pat, input logic [3:0] rep);
        start    = 1'b1;
        pattern  = pat;
        repeat_n = rep;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b0;
        pattern  = 4'h0;
        repeat_n = 4'h0;
        #10;
        vecs++;
        if (obs_g !== 4'b0000) begin
            errs++;
            $display("FAIL reset_gap: got %b want 0000", obs_g);
        end
        vecs++;
        if (obs_n !== 4'b0000) begin
            errs++;
            $display("FAIL reset_nogap: got %b want 0000", obs_n);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [3:0] exp_t [6] = '{4'b1110, 4'b1110, 4'b0110, 4'b1110, 4'b0001, 4'b0000};
        launch(4'b1101, 4'd1);
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (obs_g !== exp_t[i]) begin
                errs++;
                $display("FAIL single[%0d]: got %b want %b", i, obs_g, exp_t[i]);
            end
            step();
        end
    endtask

    task automatic test_gap_repeat();
        logic [3:0] exp_t [12] = '{4'b1110, 4'b1110, 4'b1110, 4'b0110,
                                   4'b0010, 4'b0010,
                                   4'b1110, 4'b1110, 4'b1110, 4'b0110,
                                   4'b0001, 4'b0000};
        launch(4'b1110, 4'd2);
        for (int i = 0; i < 12; i++) begin
            vecs++;
            if (obs_g !== exp_t[i]) begin
                errs++;
                $display("FAIL gap_repeat[%0d]: got %b want %b", i, obs_g, exp_t[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat = 4'b1010;
        logic [3:0] want;
        launch(pat, 4'd3);
        for (int i = 0; i < 14; i++) begin
            if (i < 12) want = {pat[3 - (i % 4)], 3'b110};
            else if (i == 12) want = 4'b0001;
            else want = 4'b0000;
            vecs++;
            if (obs_n !== want) begin
                errs++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs_n, want);
            end
            step();
        end
        // Let the GAP=2 instance finish its longer run of the same request.
        repeat (6) step();
    endtask

    task automatic test_zero_repeat();
        logic [3:0] exp_t [3] = '{4'b0001, 4'b0000, 4'b0000};
        launch(4'b1111, 4'd0);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (obs_g !== exp_t[i]) begin
                errs++;
                $display("FAIL zero_repeat[%0d]: got %b want %b", i, obs_g, exp_t[i]);
            end
            step();
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] exp_t [7] = '{4'b1110, 4'b1110, 4'b0110, 4'b1110,
                                  4'b0001, 4'b0000, 4'b0000};
        launch(4'b1101, 4'd1);
        for (int i = 0; i < 7; i++) begin
            vecs++;
            if (obs_g !== exp_t[i]) begin
                errs++;
                $display("FAIL start_ignored[%0d]: got %b want %b", i, obs_g, exp_t[i]);
            end
            // Requests seen while in SHIFT and DONE must not queue.
            start = (i >= 1 && i <= 4);
            if (i == 1) pattern = 4'b0000;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_t [6] = '{4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b0001, 4'b0000};
        launch(4'b1101, 4'd1);
        vecs++;
        if (obs_g !== 4'b1110) begin
            errs++;
            $display("FAIL abort_bit0: got %b want 1110", obs_g);
        end
        step();
        #2;
        rst = 1'b0;
        #1;
        vecs++;
        if (obs_g !== 4'b0000) begin
            errs++;
            $display("FAIL abort_async: got %b want 0000", obs_g);
        end
        step();
        step();
        vecs++;
        if (obs_g !== 4'b0000) begin
            errs++;
            $display("FAIL abort_held: got %b want 0000", obs_g);
        end
        #3;
        rst = 1'b1;
        step();
        launch(4'b0110, 4'd1);
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (obs_g !== exp_t[i]) begin
                errs++;
                $display("FAIL after_reset[%0d]: got %b want %b", i, obs_g, exp_t[i]);
            end
            step();
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_single();
        test_gap_repeat();
        test_back_to_back();
        test_zero_repeat();
        test_start_ignored();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
